esp32_mailbox_arbiter: RTL and testbench
========================================

# esp32_mailbox_arbiter

Shares the single-port 256×8 mailbox RAM (SPI memory SPACE 0) between the ESP32 SPI protocol engine and N FPGA-side clients. The SPI port has absolute priority and keeps its fixed 1-cycle read latency. Clients are served round-robin through a req/gnt handshake. After reset the block optionally zero-fills the RAM before granting clients. It sits between the SPI connector's memory port and an external synchronous RAM macro.

## Interface
- `N_CLIENTS`, 2 — number of FPGA-side requesters (1..8).
- `CLEAR_ON_RESET`, 1 — 1: sweep-fill the RAM with `FILL_VALUE` after reset; 0: start directly in RUN.
- `FILL_VALUE`, 8'h00 — value written during the init sweep.

Ports (reset: rst_n, asynchronous, active-low; clock: clk):
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `spi_wr_en` in 1 — SPI write strobe, one cycle.
- `spi_wr_addr` in 8 — SPI write address.
- `spi_wr_data` in 8 — SPI write data.
- `spi_rd_req` in 1 — SPI read strobe, one cycle.
- `spi_rd_addr` in 8 — SPI read address.
- `spi_rd_valid` out 1 — read data valid, exactly 1 cycle after `spi_rd_req`.
- `spi_rd_data` out 8 — SPI read data.
- `cl_req` in N — per-client request, level.
- `cl_we` in N — per-client write enable.
- `cl_addr` in N*8 — packed client addresses; client i uses [8i+7:8i].
- `cl_wdata` in N*8 — packed client write data.
- `cl_gnt` out N — one-hot grant pulse.
- `cl_rvalid` out N — one-hot read-data valid.
- `cl_rdata` out 8 — shared client read data.
- `ram_en` out 1 — RAM access enable.
- `ram_we` out 1 — RAM write enable.
- `ram_addr` out 8 — RAM address.
- `ram_wdata` out 8 — RAM write data.
- `ram_rdata` in 8 — RAM read data, valid 1 cycle after `ram_en && !ram_we`.
- `init_done` out 1 — high once RUN is reached.
- `spi_collision` out 1 — sticky flag for simultaneous SPI read and write.
- `defer_count` out 16 — saturating count of cycles a client request was blocked by SPI or init.

## Operation
- **States:** INIT → RUN.
  - Reset enters INIT when `CLEAR_ON_RESET`=1, otherwise RUN.
  - INIT writes `FILL_VALUE` to addresses 0..255, one per cycle.
  - After the cycle that writes address 255, the state moves to RUN and `init_done` goes high.
- **Per-cycle RAM port priority:**
  1. SPI write.
  2. SPI read.
  3. Init sweep (INIT only).
  4. Round-robin client (RUN only).
- **SPI accesses are never delayed.**
  - A SPI access during INIT pauses the sweep; the sweep address does not advance that cycle.
  - A SPI write to an address the sweep has not yet reached is later overwritten by `FILL_VALUE`. This is accepted.
- **`spi_wr_en` and `spi_rd_req` in the same cycle:**
  - The write is performed.
  - `spi_rd_valid` still pulses next cycle, with `spi_rd_data`=8'hFF.
  - `spi_collision` sets and stays set until reset.
- **Client handshake:**
  - A client raises `cl_req[i]` and holds `cl_we`, `cl_addr` and `cl_wdata` stable until `cl_gnt[i]`.
  - `cl_gnt[i]` is combinational and asserted in the same cycle the RAM port carries that client's access.
  - The write completes in the grant cycle.
  - For a read, `cl_rvalid[i]` and `cl_rdata` appear on the next cycle.
  - A `cl_req` still high on the cycle after `cl_gnt` is treated as a new request.
- **Round-robin:**
  - The pointer `rr` (reset 0) selects the first requesting client at index ≥ `rr`, wrapping modulo N.
  - After a grant to client k, `rr` becomes (k+1) mod N.
  - `rr` is unchanged in cycles with no client grant.
- **`defer_count`** increments, saturating at 16'hFFFF, in every cycle where any `cl_req` is high and no `cl_gnt` is asserted.
- **Read-return routing:** a registered source tag {NONE, SPI, CLIENT(k), COLLIDE} routes `ram_rdata` to the correct output.

## Timing
- **Reset values:**
  - All `cl_gnt`, `cl_rvalid`, `spi_rd_valid`, `ram_en`, `ram_we`: 0.
  - `spi_rd_data`, `cl_rdata`, `ram_addr`, `ram_wdata`: 0.
  - `init_done` = !`CLEAR_ON_RESET`.
  - `spi_collision`: 0. `defer_count`: 0.
  - Source tag: NONE. `rr`: 0.
- **Combinational paths:** `ram_*` and `cl_gnt` are combinational from inputs plus state. The read-data outputs are registered.
- **SPI read latency:** exactly 1 cycle; back-to-back SPI reads are supported at 1/cycle.
- **Client grant latency:**
  - Minimum 0 cycles: grant in the same cycle as `req` when SPI is idle.
  - Worst case in RUN with sparse SPI traffic: N−1 client grants plus the SPI cycles that occur in between.
- **Init sweep:** 256 cycles with no SPI traffic; each SPI cycle during INIT extends it by one.
- **Reset asserted mid-operation:** discards any pending rvalid, returns to INIT (or RUN per parameter), and restarts the sweep from address 0.

## Structure
- **Package `esp32_mailbox_pkg`:**
  - `rd_src_t` enum (NONE, SPI, CLIENT, COLLIDE).
  - `state_t` (INIT, RUN).
  - `MBOX_ADDR_W`=8, `MBOX_DEPTH`=256, `COLLIDE_DATA`=8'hFF.
- **Sub-module `esp32_rr_arbiter`:** parameterised N-way round-robin pick. Inputs: `req` vector, `rr` pointer, `enable`. Outputs: one-hot `gnt` and the grant index. Purely combinational; the pointer register lives in the parent.

## Test plan
- **Init sweep:** reset with `CLEAR_ON_RESET`=1, no traffic → `init_done` rises after exactly 256 cycles; a SPI read of 0x7F returns 8'h00.
- **SPI during INIT:** 10 SPI writes issued during INIT → sweep takes 266 cycles; `cl_gnt` stays 0 throughout INIT even with `cl_req`=2'b11; `defer_count` counts those cycles.
- **SPI vs client read, same address:** client 0 writes 0x5A to addr 0x10; then SPI reads 0x10 in the same cycle client 1 requests a read of 0x10 → `spi_rd_valid`=1 with 0x5A next cycle; client 1 granted one cycle later and its `cl_rvalid[1]` carries 0x5A; `defer_count`=1.
- **Round-robin fairness:** both clients hold `req` continuously for 6 grants with SPI idle → grant order 0,1,0,1,0,1.
- **Simultaneous SPI read and write:** `spi_wr_en` (addr 3, 0xC3) and `spi_rd_req` (addr 3) in the same cycle → `spi_rd_data`=0xFF next cycle; `spi_collision`=1; a later read of addr 3 returns 0xC3.
- **Reset mid-operation:** assert `rst_n` low the cycle after a client read grant → `cl_rvalid` never pulses; `rr`=0; sweep restarts at address 0.

Source files
------------

// File: rtl/esp32_mailbox_pkg.sv
// Shared types and constants for the ESP32 mailbox RAM arbiter.
// Read-return source tags, FSM encodings and mailbox geometry.
package esp32_mailbox_pkg;

  localparam int MBOX_ADDR_W = 8;
  localparam int MBOX_DEPTH  = 256;
  localparam logic [7:0] COLLIDE_DATA = 8'hFF;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_SPI,
    SRC_CLIENT,
    SRC_COLLIDE
  } rd_src_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_INIT = 1'b0;
  localparam state_t ST_RUN  = 1'b1;

  function automatic logic [15:0] sat_inc16(
    input logic [15:0] v
  );
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/esp32_mailbox_if.sv
// Bus bundle between SPI engine, FPGA clients and the RAM macro.
// slave = arbiter side, master = requesters plus RAM model.
interface esp32_mailbox_if #(
  parameter int N = 2
) ();

  logic         spi_wr_en;
  logic [7:0]   spi_wr_addr;
  logic [7:0]   spi_wr_data;
  logic         spi_rd_req;
  logic [7:0]   spi_rd_addr;
  logic         spi_rd_valid;
  logic [7:0]   spi_rd_data;

  logic [N-1:0]   cl_req;
  logic [N-1:0]   cl_we;
  logic [N*8-1:0] cl_addr;
  logic [N*8-1:0] cl_wdata;
  logic [N-1:0]   cl_gnt;
  logic [N-1:0]   cl_rvalid;
  logic [7:0]     cl_rdata;

  logic         ram_en;
  logic         ram_we;
  logic [7:0]   ram_addr;
  logic [7:0]   ram_wdata;
  logic [7:0]   ram_rdata;

  modport master (
    output spi_wr_en, spi_wr_addr, spi_wr_data,
    output spi_rd_req, spi_rd_addr,
    input  spi_rd_valid, spi_rd_data,
    output cl_req, cl_we, cl_addr, cl_wdata,
    input  cl_gnt, cl_rvalid, cl_rdata,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  spi_wr_en, spi_wr_addr, spi_wr_data,
    input  spi_rd_req, spi_rd_addr,
    output spi_rd_valid, spi_rd_data,
    input  cl_req, cl_we, cl_addr, cl_wdata,
    output cl_gnt, cl_rvalid, cl_rdata,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

endinterface

// File: rtl/esp32_mailbox_arbiter_rr.sv
// Combinational N-way round-robin pick starting at pointer rr.
// The pointer register is owned by the parent.
module esp32_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          valid
);

  // first requester at or after rr, wrapping
  always_comb begin
    int c;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    if (enable) begin
      for (int off = 0; off < N; off++) begin
        c = (int'(rr) + off) % N;
        if (!valid && req[c]) begin
          valid  = 1'b1;
          gnt[c] = 1'b1;
          idx    = IW'(c);
        end
      end
    end
  end

endmodule

// File: rtl/esp32_mailbox_arbiter.sv
// Shares the single-port mailbox RAM between SPI and FPGA clients.
// SPI has absolute priority; clients are served round-robin.
module esp32_mailbox_arbiter
  import esp32_mailbox_pkg::*;
#(
  parameter int         N_CLIENTS      = 2,
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] FILL_VALUE     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  esp32_mailbox_if.slave       mbox,
  output logic                 init_done,
  output logic                 spi_collision,
  output logic [15:0]          defer_count
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t                 state_q, state_d;
  logic [MBOX_ADDR_W-1:0] sweep_q, sweep_d;
  logic [IW-1:0]          rr_q, rr_d;
  rd_src_t                src_q, src_d;
  logic [IW-1:0]          tag_q, tag_d;
  logic                   coll_q, coll_d;
  logic [15:0]            defer_q, defer_d;

  logic                 spi_wr;
  logic                 spi_rd;
  logic                 sel_wr;
  logic                 sel_rd;
  logic                 sel_sw;
  logic                 arb_en;
  logic [N_CLIENTS-1:0] arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_vld;
  logic                 sel_we;
  logic [7:0]           sel_addr;
  logic [7:0]           sel_wdata;

  assign spi_wr = mbox.spi_wr_en;
  assign spi_rd = mbox.spi_rd_req;

  // mutually exclusive RAM port owners, highest priority first
  assign sel_wr = rst_n && spi_wr;
  assign sel_rd = rst_n && spi_rd && !spi_wr;
  assign sel_sw = rst_n && !spi_wr && !spi_rd
               && (state_q == ST_INIT);
  assign arb_en = rst_n && !spi_wr && !spi_rd
               && (state_q == ST_RUN);

  esp32_rr_arbiter #(
    .N  (N_CLIENTS),
    .IW (IW)
  ) u_rr (
    .req    (mbox.cl_req),
    .rr     (rr_q),
    .enable (arb_en),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .valid  (arb_vld)
  );

  assign sel_we    = mbox.cl_we[arb_idx];
  assign sel_addr  = mbox.cl_addr[8*arb_idx +: 8];
  assign sel_wdata = mbox.cl_wdata[8*arb_idx +: 8];

  assign mbox.cl_gnt = arb_gnt;

  // drive the RAM port from whichever source owns it this cycle
  always_comb begin
    mbox.ram_en    = 1'b0;
    mbox.ram_we    = 1'b0;
    mbox.ram_addr  = '0;
    mbox.ram_wdata = '0;
    unique case (1'b1)
      sel_wr: begin
        mbox.ram_en    = 1'b1;
        mbox.ram_we    = 1'b1;
        mbox.ram_addr  = mbox.spi_wr_addr;
        mbox.ram_wdata = mbox.spi_wr_data;
      end
      sel_rd: begin
        mbox.ram_en   = 1'b1;
        mbox.ram_addr = mbox.spi_rd_addr;
      end
      sel_sw: begin
        mbox.ram_en    = 1'b1;
        mbox.ram_we    = 1'b1;
        mbox.ram_addr  = sweep_q;
        mbox.ram_wdata = FILL_VALUE;
      end
      arb_vld: begin
        mbox.ram_en    = 1'b1;
        mbox.ram_we    = sel_we;
        mbox.ram_addr  = sel_addr;
        mbox.ram_wdata = sel_wdata;
      end
      default: ;
    endcase
  end

  // next-state: sweep, pointer, read tag, flags
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    rr_d    = rr_q;
    src_d   = SRC_NONE;
    tag_d   = '0;
    coll_d  = coll_q | (spi_wr & spi_rd);
    defer_d = defer_q;
    if (sel_sw) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == 8'hFF)
        state_d = ST_RUN;
    end
    if (arb_vld)
      rr_d = IW'((int'(arb_idx) + 1) % N_CLIENTS);
    if (spi_wr && spi_rd)
      src_d = SRC_COLLIDE;
    else if (spi_rd)
      src_d = SRC_SPI;
    else if (arb_vld && !sel_we) begin
      src_d = SRC_CLIENT;
      tag_d = arb_idx;
    end
    if ((|mbox.cl_req) && !arb_vld)
      defer_d = sat_inc16(defer_q);
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      sweep_q <= '0;
      rr_q    <= '0;
      src_q   <= SRC_NONE;
      tag_q   <= '0;
      coll_q  <= 1'b0;
      defer_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      coll_q  <= coll_d;
      defer_q <= defer_d;
    end
  end

  // steer the RAM read-return by the registered tag
  always_comb begin
    mbox.spi_rd_valid = 1'b0;
    mbox.spi_rd_data  = '0;
    mbox.cl_rvalid    = '0;
    mbox.cl_rdata     = '0;
    unique case (src_q)
      SRC_SPI: begin
        mbox.spi_rd_valid = 1'b1;
        mbox.spi_rd_data  = mbox.ram_rdata;
      end
      SRC_COLLIDE: begin
        mbox.spi_rd_valid = 1'b1;
        mbox.spi_rd_data  = COLLIDE_DATA;
      end
      SRC_CLIENT: begin
        mbox.cl_rvalid[tag_q] = 1'b1;
        mbox.cl_rdata         = mbox.ram_rdata;
      end
      default: ;
    endcase
  end

  assign init_done     = (state_q == ST_RUN);
  assign spi_collision = coll_q;
  assign defer_count   = defer_q;

endmodule

// File: tb/tb_esp32_mailbox_arbiter.sv
// Directed bench for esp32_mailbox_arbiter with a behavioural RAM.
// Inputs change on negedge; outputs are sampled 1 time unit later.
module tb_esp32_mailbox_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_done;
  logic spi_collision;
  logic [15:0] defer_count;

  int checks = 0;
  int errors = 0;

  esp32_mailbox_if #(.N(2)) mbox ();

  esp32_mailbox_arbiter #(
    .N_CLIENTS      (2),
    .CLEAR_ON_RESET (1'b1),
    .FILL_VALUE     (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mbox          (mbox),
    .init_done     (init_done),
    .spi_collision (spi_collision),
    .defer_count   (defer_count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
    end else if (mbox.ram_en) begin
      if (mbox.ram_we) mem[mbox.ram_addr] <= mbox.ram_wdata;
      else mbox.ram_rdata <= mem[mbox.ram_addr];
    end
  end

  typedef struct {
    logic       wr;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       rd;
    logic [7:0] ra;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] x_gnt;
    logic       x_en;
    logic       x_we;
    logic [7:0] x_addr;
    logic [7:0] x_wd;
    logic       x_srv;
    logic [7:0] x_srd;
    logic [1:0] x_crv;
    logic [7:0] x_crd;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    mbox.spi_wr_en   = 1'b0;
    mbox.spi_wr_addr = '0;
    mbox.spi_wr_data = '0;
    mbox.spi_rd_req  = 1'b0;
    mbox.spi_rd_addr = '0;
    mbox.cl_req      = '0;
    mbox.cl_we       = '0;
    mbox.cl_addr     = '0;
    mbox.cl_wdata    = '0;
  endtask

  task automatic wait_init(input bit with_spi,
                           output int n,
                           output int bad);
    n = 0;
    bad = 0;
    while (!init_done && n < 1000) begin
      mbox.spi_wr_en   = with_spi && n >= 5 && n < 15;
      mbox.spi_wr_addr = 8'hF0;
      mbox.spi_wr_data = 8'h77;
      #1;
      if (mbox.cl_gnt != 0 || mbox.cl_rvalid != 0) bad++;
      @(negedge clk);
      n++;
    end
    mbox.spi_wr_en = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    mbox.spi_wr_en   = v.wr;
    mbox.spi_wr_addr = v.wa;
    mbox.spi_wr_data = v.wd;
    mbox.spi_rd_req  = v.rd;
    mbox.spi_rd_addr = v.ra;
    mbox.cl_req      = v.req;
    mbox.cl_we       = v.we;
    mbox.cl_addr     = {v.a1, v.a0};
    mbox.cl_wdata    = {v.d1, v.d0};
  endtask

  initial begin
    int n;
    int bad;

    tbl[0]  = '{0,8'h00,8'h00,0,8'h00,2'b01,2'b01,8'h10,8'h00,8'h5A,8'h00, 2'b01,1,1,8'h10,8'h5A,0,8'h00,2'b00,8'h00};
    tbl[1]  = '{0,8'h00,8'h00,1,8'h10,2'b10,2'b00,8'h00,8'h10,8'h00,8'h00, 2'b00,1,0,8'h10,8'h00,0,8'h00,2'b00,8'h00};
    tbl[2]  = '{0,8'h00,8'h00,0,8'h00,2'b10,2'b00,8'h00,8'h10,8'h00,8'h00, 2'b10,1,0,8'h10,8'h00,1,8'h5A,2'b00,8'h00};
    tbl[3]  = '{0,8'h00,8'h00,0,8'h00,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 2'b00,0,0,8'h00,8'h00,0,8'h00,2'b10,8'h5A};
    tbl[4]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b01,1,1,8'h20,8'hA0,0,8'h00,2'b00,8'h00};
    tbl[5]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b10,1,1,8'h21,8'hB1,0,8'h00,2'b00,8'h00};
    tbl[6]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b01,1,1,8'h20,8'hA0,0,8'h00,2'b00,8'h00};
    tbl[7]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b10,1,1,8'h21,8'hB1,0,8'h00,2'b00,8'h00};
    tbl[8]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b01,1,1,8'h20,8'hA0,0,8'h00,2'b00,8'h00};
    tbl[9]  = '{0,8'h00,8'h00,0,8'h00,2'b11,2'b11,8'h20,8'h21,8'hA0,8'hB1, 2'b10,1,1,8'h21,8'hB1,0,8'h00,2'b00,8'h00};
    tbl[10] = '{1,8'h03,8'hC3,1,8'h03,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 2'b00,1,1,8'h03,8'hC3,0,8'h00,2'b00,8'h00};
    tbl[11] = '{0,8'h00,8'h00,1,8'h03,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 2'b00,1,0,8'h03,8'h00,1,8'hFF,2'b00,8'h00};
    tbl[12] = '{0,8'h00,8'h00,0,8'h00,2'b01,2'b00,8'h21,8'h00,8'h00,8'h00, 2'b01,1,0,8'h21,8'h00,1,8'hC3,2'b00,8'h00};
    tbl[13] = '{0,8'h00,8'h00,0,8'h00,2'b10,2'b00,8'h00,8'h20,8'h00,8'h00, 2'b10,1,0,8'h20,8'h00,0,8'h00,2'b01,8'hB1};
    tbl[14] = '{0,8'h00,8'h00,0,8'h00,2'b00,2'b00,8'h00,8'h00,8'h00,8'h00, 2'b00,0,0,8'h00,8'h00,0,8'h00,2'b10,8'hA0};

    idle();
    #1;
    rst_n = 1'b0;
    mbox.cl_req = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    chk("rst init_done", init_done, 0);
    chk("rst spi_rd_valid", mbox.spi_rd_valid, 0);
    chk("rst spi_rd_data", mbox.spi_rd_data, 0);
    chk("rst cl_rvalid", mbox.cl_rvalid, 0);
    chk("rst cl_rdata", mbox.cl_rdata, 0);
    chk("rst cl_gnt", mbox.cl_gnt, 0);
    chk("rst ram_en", mbox.ram_en, 0);
    chk("rst collision", spi_collision, 0);
    chk("rst defer", defer_count, 0);

    // plain init sweep
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    chk("sweep0 ram_en", mbox.ram_en, 1);
    chk("sweep0 ram_we", mbox.ram_we, 1);
    chk("sweep0 ram_addr", mbox.ram_addr, 0);
    wait_init(1'b0, n, bad);
    chk("init cycles", n, 256);
    mbox.spi_rd_req  = 1'b1;
    mbox.spi_rd_addr = 8'h7F;
    @(negedge clk);
    idle();
    #1;
    chk("rd7f valid", mbox.spi_rd_valid, 1);
    chk("rd7f data", mbox.spi_rd_data, 8'h00);

    // SPI traffic during INIT with both clients requesting
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mbox.cl_req = 2'b11;
    wait_init(1'b1, n, bad);
    mbox.cl_req = 2'b00;
    chk("init spi cycles", n, 266);
    chk("init no gnt", bad, 0);
    chk("init defer", defer_count, 266);

    // table of RUN-state vectors from a fresh reset
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_init(1'b0, n, bad);
    chk("init3 cycles", n, 256);
    for (int i = 0; i < NV; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("v%0d cl_gnt", i), mbox.cl_gnt, tbl[i].x_gnt);
      chk($sformatf("v%0d ram_en", i), mbox.ram_en, tbl[i].x_en);
      chk($sformatf("v%0d ram_we", i), mbox.ram_we, tbl[i].x_we);
      chk($sformatf("v%0d ram_addr", i), mbox.ram_addr, tbl[i].x_addr);
      if (tbl[i].x_we)
        chk($sformatf("v%0d ram_wdata", i), mbox.ram_wdata, tbl[i].x_wd);
      chk($sformatf("v%0d spi_rv", i), mbox.spi_rd_valid, tbl[i].x_srv);
      chk($sformatf("v%0d spi_rd", i), mbox.spi_rd_data, tbl[i].x_srd);
      chk($sformatf("v%0d cl_rv", i), mbox.cl_rvalid, tbl[i].x_crv);
      chk($sformatf("v%0d cl_rd", i), mbox.cl_rdata, tbl[i].x_crd);
      @(negedge clk);
    end
    idle();
    chk("table defer", defer_count, 1);
    chk("table collision", spi_collision, 1);

    // reset right after a client read grant
    mbox.cl_req     = 2'b01;
    mbox.cl_we      = 2'b00;
    mbox.cl_addr    = {8'h00, 8'h20};
    #1;
    chk("mid gnt", mbox.cl_gnt, 2'b01);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    idle();
    #1;
    chk("mid rvalid", mbox.cl_rvalid, 0);
    chk("mid init_done", init_done, 0);
    chk("mid collision", spi_collision, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid sweep addr", mbox.ram_addr, 0);
    chk("mid sweep en", mbox.ram_en, 1);
    wait_init(1'b0, n, bad);
    chk("mid init cycles", n, 256);
    chk("mid no rvalid", bad, 0);
    mbox.cl_req = 2'b11;
    #1;
    chk("mid rr reset", mbox.cl_gnt, 2'b01);
    @(negedge clk);
    idle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
